// File: rtl/regfile.sv
// 32 x DATA_W integer register file with two combinational read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data (and clear busy) on the read ports.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_num,
    input  logic              wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_num,
    output logic              busy1,
    output logic              busy2,
    output logic              stall
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic wb_hit;
    logic issue_hit;

    assign wb_hit    = wb_reg && (wb_num != '0);
    assign issue_hit = issue_en && (issue_num != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            if (gi == 0) begin : g_zero
                // x0 is hard-wired: never written, never busy.
                assign busy_d[gi] = 1'b0;
                always_ff @(posedge clk) begin
                    regs_q[gi] <= '0;
                end
            end else begin : g_gpr
                // Set beats clear: a same-cycle issue names a younger producer.
                assign busy_d[gi] = rst                          ? 1'b0 :
                                    (issue_hit && issue_num == IDX) ? 1'b1 :
                                    (wb_hit && wb_num == IDX)       ? 1'b0 :
                                    busy_q[gi];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_q[gi] <= '0;
                    end else if (wb_hit && wb_num == IDX) begin
                        regs_q[gi] <= wb_data;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    logic [1:0]        re_v;
    logic [ADDR_W-1:0] raddr_v [2];
    logic [DATA_W-1:0] rdata_v [2];
    logic [1:0]        busy_v;

    assign re_v       = {re2, re1};
    assign raddr_v[0] = raddr1;
    assign raddr_v[1] = raddr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            always_comb begin
                rdata_v[gi] = '0;
                busy_v[gi]  = 1'b0;
                if (!rst && re_v[gi] && raddr_v[gi] != '0) begin
                    rdata_v[gi] = regs_q[raddr_v[gi]];
                    busy_v[gi]  = busy_q[raddr_v[gi]];
`ifdef REGFILE_BYPASS_EN
                    if (wb_hit && wb_num == raddr_v[gi]) begin
                        rdata_v[gi] = wb_data;
                        busy_v[gi]  = 1'b0;
                    end
`endif
                end
            end
        end
    endgenerate

    assign rdata1 = rdata_v[0];
    assign rdata2 = rdata_v[1];
    assign busy1  = busy_v[0];
    assign busy2  = busy_v[1];
    assign stall  = busy_v[0] | busy_v[1];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table followed by random traffic
// checked against an array-based reference model.
module tb_regfile;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_num;
    logic        wb_reg;
    logic [31:0] wb_data;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        issue_en;
    logic [4:0]  issue_num;
    logic        busy1, busy2, stall;

    always #5 clk = ~clk;

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wb_num(wb_num), .wb_reg(wb_reg), .wb_data(wb_data),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .issue_en(issue_en), .issue_num(issue_num),
        .busy1(busy1), .busy2(busy2), .stall(stall)
    );

    typedef struct {
        logic        rst;
        logic        wb_reg;
        logic [4:0]  wb_num;
        logic [31:0] wb_data;
        logic        re1;
        logic [4:0]  a1;
        logic        re2;
        logic [4:0]  a2;
        logic        iss;
        logic [4:0]  inum;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_b1;
        logic        e_b2;
        logic        e_st;
    } vec_t;

    int vec_cnt    = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic vec_t mkv(logic r, logic w, logic [4:0] wn, logic [31:0] wd,
                                 logic e1, logic [4:0] a1, logic e2, logic [4:0] a2,
                                 logic is, logic [4:0] inum,
                                 logic [31:0] d1, logic [31:0] d2,
                                 logic b1, logic b2, logic st);
        vec_t v;
        v.rst = r; v.wb_reg = w; v.wb_num = wn; v.wb_data = wd;
        v.re1 = e1; v.a1 = a1; v.re2 = e2; v.a2 = a2;
        v.iss = is; v.inum = inum;
        v.e_d1 = d1; v.e_d2 = d2; v.e_b1 = b1; v.e_b2 = b2; v.e_st = st;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; wb_reg = v.wb_reg; wb_num = v.wb_num; wb_data = v.wb_data;
        re1 = v.re1; raddr1 = v.a1; re2 = v.re2; raddr2 = v.a2;
        issue_en = v.iss; issue_num = v.inum;
    endtask

    // Spec-level read: forced zero in reset, disabled or x0; optional forwarding; else stored state.
    task automatic model_read(input logic e, input logic [4:0] a,
                              output logic [31:0] d, output logic b);
        d = '0; b = 1'b0;
        if (!rst && e && a != 0) begin
            if (BYP && wb_reg && wb_num != 0 && wb_num == a) begin
                d = wb_data; b = 1'b0;
            end else begin
                d = m_regs[a]; b = m_busy[a];
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        end else begin
            if (wb_reg && wb_num != 0) begin
                m_regs[wb_num] = wb_data;
                m_busy[wb_num] = 1'b0;
            end
            if (issue_en && issue_num != 0) m_busy[issue_num] = 1'b1;
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t tbl [17];

    initial begin
        logic [31:0] d1, d2;
        logic        b1, b2;
        vec_t        v;

        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end

        tbl[0]  = mkv(1, 1, 5'd3, 32'h55, 1, 5'd3, 1, 5'd4, 1, 5'd4, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 1, 5'd3, 1, 5'd4, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd1, 1, 5'd31, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tbl[4]  = mkv(0, 1, 5'd0, 32'h12345678, 1, 5'd0, 1, 5'd5, 1, 5'd0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[5]  = mkv(0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 0, 1, 5'd5, 1, 5'd6, 1, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[7]  = mkv(0, 0, 0, 0, 1, 5'd7, 1, 5'd5, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1);
        tbl[8]  = mkv(0, 1, 5'd7, 32'hA5, 1, 5'd7, 1, 5'd7, 0, 0,
                      BYP ? 32'hA5 : 32'h0, BYP ? 32'hA5 : 32'h0, !BYP, !BYP, !BYP);
        tbl[9]  = mkv(0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 0, 0, 32'hA5, 0, 0, 0, 0);
        tbl[10] = mkv(0, 0, 0, 0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 0, 0, 0, 0, 0);
        tbl[11] = mkv(0, 1, 5'd9, 32'h1, 1, 5'd9, 0, 5'd0, 1, 5'd9,
                      BYP ? 32'h1 : 32'h0, 0, !BYP, 0, !BYP);
        tbl[12] = mkv(0, 0, 0, 0, 1, 5'd9, 1, 5'd9, 0, 0, 32'h1, 32'h1, 1, 1, 1);
        tbl[13] = mkv(1, 1, 5'd3, 32'h55, 1, 5'd9, 1, 5'd9, 1, 5'd4, 0, 0, 0, 0, 0);
        tbl[14] = mkv(0, 0, 0, 0, 1, 5'd3, 1, 5'd4, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mkv(0, 1, 5'd3, 32'h55, 1, 5'd3, 1, 5'd4, 1, 5'd4,
                      BYP ? 32'h55 : 32'h0, 0, 0, 0, 0);
        tbl[16] = mkv(0, 0, 0, 0, 1, 5'd3, 1, 5'd4, 0, 0, 32'h55, 0, 0, 1, 1);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d rdata1", i), rdata1, tbl[i].e_d1);
            chk($sformatf("vec%0d rdata2", i), rdata2, tbl[i].e_d2);
            chk($sformatf("vec%0d busy1", i), {31'b0, busy1}, {31'b0, tbl[i].e_b1});
            chk($sformatf("vec%0d busy2", i), {31'b0, busy2}, {31'b0, tbl[i].e_b2});
            chk($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].e_st});
            $display("vec %0d: rd1=%h rd2=%h b1=%b b2=%b st=%b", i, rdata1, rdata2, busy1, busy2, stall);
            finish_cycle();
        end

        // Random traffic; narrow index range half the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            v.rst     = ($urandom_range(0, 49) == 0);
            v.wb_reg  = $urandom_range(0, 1);
            v.wb_num  = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            v.wb_data = $urandom;
            v.re1     = ($urandom_range(0, 7) != 0);
            v.a1      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            v.re2     = ($urandom_range(0, 7) != 0);
            v.a2      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            v.iss     = $urandom_range(0, 1);
            v.inum    = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            drive(v);
            #1;
            model_read(re1, raddr1, d1, b1);
            model_read(re2, raddr2, d2, b2);
            chk("rand rdata1", rdata1, d1);
            chk("rand rdata2", rdata2, d2);
            chk("rand busy1", {31'b0, busy1}, {31'b0, b1});
            chk("rand busy2", {31'b0, busy2}, {31'b0, b2});
            chk("rand stall", {31'b0, stall}, {31'b0, b1 | b2});
            if (n % 50 == 0)
                $display("rand %0d: rst=%b a1=%0d rd1=%h a2=%0d rd2=%h st=%b", n, rst, raddr1, rdata1, raddr2, rdata2, stall);
            finish_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

Integer register file for the single-cycle RISC-V core. It receives the write-back stage's register-write triple (number, enable, data), stores 32 x 32-bit general registers, and serves two combinational read ports to the decode stage. A per-register busy scoreboard tracks destinations issued but not yet written back, and raises a stall request when a source operand is still pending.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- wb_num  input  5  write-back destination index
- wb_reg  input  1  write-back enable
- wb_data  input  32  write-back value
- re1  input  1  read port 1 enable
- raddr1  input  5  read port 1 index
- rdata1  output  32  read port 1 data
- re2  input  1  read port 2 enable
- raddr2  input  5  read port 2 index
- rdata2  output  32  read port 2 data
- issue_en  input  1  decode issued an instruction that writes a register
- issue_num  input  5  destination index of that instruction
- busy1  output  1  port 1 source pending
- busy2  output  1  port 2 source pending
- stall  output  1  busy1 | busy2

## Operation
- Storage: regs[0..31], DATA_W bits each; busy[0..31], 1 bit each.
- Write: at the clock edge, if wb_reg=1 and wb_num!=0, regs[wb_num] <= wb_data. A write to x0 is dropped silently.
- x0: always reads 0; busy[0] is never set.
- Read port n (combinational):
  - re_n=0: rdata_n=0, busy_n=0.
  - raddr_n=0: rdata_n=0, busy_n=0.
  - Otherwise: rdata_n=regs[raddr_n] (subject to the bypass rule under Configuration); busy_n=busy[raddr_n] (subject to the same rule).
- Scoreboard, updated at the clock edge:
  - Clear: wb_reg=1 and wb_num!=0 -> busy[wb_num] <= 0.
  - Set: issue_en=1 and issue_num!=0 -> busy[issue_num] <= 1.
  - Same index set and cleared in one cycle: set wins, because the new producer is younger.
- stall = busy1 | busy2. The block does not gate issue_en itself; the decode stage must hold issue_en low while stall=1.

## Timing
- Reset: while rst=1 at the edge, all regs <= 0 and all busy <= 0. While rst=1, rdata1, rdata2, busy1, busy2 and stall are forced to 0 combinationally. A write-back or issue presented in a reset cycle is discarded.
- Write latency: one edge. A value written at edge N is readable from the storage array after edge N.
- Read latency: zero (combinational from raddr_n, re_n and state).
- Scoreboard latency: busy is visible the cycle after issue and clears the cycle after write-back (earlier with bypass).
- Both read ports may address the same register. Results are identical on both ports.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In the same cycle, if wb_reg=1, wb_num!=0 and raddr_n==wb_num (port enabled), then rdata_n=wb_data and busy_n=0. Same-cycle write-then-read costs no stall.
- Not defined:
  - rdata_n always comes from the storage array, and busy_n reflects the stored bit.
  - A read that coincides with a write to the same index returns the old value and may stall one extra cycle.

## Test plan
- Reset, then read x1..x31 on both ports -> all 0; stall=0.
- Write x5=0xDEADBEEF, next cycle read raddr1=5, raddr2=5 -> rdata1=rdata2=0xDEADBEEF.
- Write x0=0x12345678, then read x0 -> 0. Also issue_num=0, then read x0 -> busy1=0.
- Issue x7, next cycle read x7 -> busy1=1, stall=1. Write back x7=0xA5 -> with REGFILE_BYPASS_EN, in that same cycle rdata1=0xA5 and busy1=0; without it, busy1=1 that cycle, then rdata1=0xA5 and busy1=0 the next cycle.
- Same cycle: issue x9 and write back x9=0x1 (x9 previously busy) -> after the edge busy[9]=1 and regs[9]=0x1.
- Write x3=0x55 and issue x4, with rst=1 in that cycle -> after the edge regs[3]=0, busy[4]=0; all outputs 0 while rst=1.
